aes_encr_pipe_ctrl: RTL and testbench

- Sequencer and flow controller for the pipelined AES-128 encryption datapath: the key expansion plus LAT registered round stages.
- Accepts plaintext blocks over a valid/ready handshake and issues at most one block per cycle into the datapath.
- Tracks in-flight blocks with a valid/tag shift register. Captures ciphertext into an output FIFO with backpressure.
- Owns the secret-key register. Guarantees the key never changes while any block is in flight.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_ctrl_fifo.sv | 48 ++++
 rtl/aes_encr_pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_aes_encr_pipe_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES encryption pipeline controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int N              = 128;
  localparam int LAT_DEFAULT    = 10;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TAG_W_DEFAULT  = 4;

  localparam int INFL_W_DEFAULT   = $clog2(LAT_DEFAULT + 1);
  localparam int FIFO_CNT_W_DEF   = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/aes_ctrl_fifo.sv
// First-word-fall-through FIFO holding captured ciphertext and tags.
// Latency: one edge from push to head visible; head is combinational from storage.
// Backpressure: upstream credit keeps it from filling; push when full is ignored.
module aes_ctrl_fifo #(
  parameter int W     = 132,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         full;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/aes_encr_pipe_ctrl.sv
// Sequencer for the pipelined AES-128 datapath: admits blocks, tracks them, buffers ciphertext.
// Latency: accept to out_valid is LAT+1 edges when the output FIFO is empty.
// Backpressure: in_ready is credit based (in flight + buffered < FIFO_DEPTH); the datapath never stalls.
module aes_encr_pipe_ctrl
  import aes_pkg::*;
#(
  parameter int N          = aes_pkg::N,
  parameter int LAT        = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [N-1:0]     key_in,
  output logic             key_ack,
  output logic             key_valid,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [N-1:0]     dp_plaintext,
  output logic [N-1:0]     dp_key,
  input  logic [N-1:0]     dp_ciphertext,
  output logic             busy
);

  localparam int INFL_W = $clog2(LAT + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W  = 16;

  ctrl_state_t        state;
  ctrl_state_t        state_nxt;
  logic [INFL_W-1:0]  inflight;
  logic [LAT-1:0]     sr_vld;
  logic [TAG_W-1:0]   sr_tag [LAT];
  logic               cap_vld;
  logic [TAG_W-1:0]   cap_tag;
  logic               accept;
  logic               push;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   occupancy;
  logic [N+TAG_W-1:0] fifo_head;

  assign accept    = in_valid && in_ready;
  assign push      = cap_vld;
  // Current-cycle values only: a pop this cycle does not return its credit until next cycle.
  assign occupancy = SUM_W'(inflight) + SUM_W'(fifo_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NOKEY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      NOKEY:   if (key_load) state_nxt = RUN;
      RUN:     if (key_load) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = RUN;
      default: state_nxt = NOKEY;
    endcase
  end

  // A pending key request blocks new blocks so the key swap cannot starve.
  always_comb begin
    in_ready = 1'b0;
    key_ack  = 1'b0;
    unique case (state)
      NOKEY:   key_ack  = key_load;
      RUN:     in_ready = !key_load && (occupancy < SUM_W'(FIFO_DEPTH));
      DRAIN:   key_ack  = (inflight == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_key       <= '0;
      key_valid    <= 1'b0;
      dp_plaintext <= '0;
    end else begin
      if (key_ack) begin
        dp_key    <= key_in;
        key_valid <= 1'b1;
      end
      if (accept) dp_plaintext <= in_data;
    end
  end

  // Tag/valid travel alongside the datapath; the extra cap stage lines up with dp_ciphertext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld  <= '0;
      for (int i = 0; i < LAT; i++) sr_tag[i] <= '0;
      cap_vld <= 1'b0;
      cap_tag <= '0;
    end else begin
      sr_vld    <= {sr_vld[LAT-2:0], accept};
      sr_tag[0] <= accept ? in_tag : '0;
      for (int i = 1; i < LAT; i++) sr_tag[i] <= sr_tag[i-1];
      cap_vld   <= sr_vld[LAT-1];
      cap_tag   <= sr_tag[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({accept, push})
        2'b10:   inflight <= inflight + INFL_W'(1);
        2'b01:   inflight <= inflight - INFL_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  aes_ctrl_fifo #(
    .W     (N + TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({dp_ciphertext, cap_tag}),
    .pop      (out_valid && out_ready),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[N+TAG_W-1:TAG_W];
  assign out_tag   = fifo_head[TAG_W-1:0];
  assign busy      = (inflight != '0) || !fifo_empty;

endmodule

// File: tb/tb_aes_encr_pipe_ctrl.sv
// Bench for aes_encr_pipe_ctrl: datapath stub, queue-based reference model, directed scenarios.
module tb_aes_encr_pipe_ctrl;

  localparam int LAT   = 10;
  localparam int DEPTH = 4;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2    = 128'hfedcba98765432100123456789abcdef;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ack, key_valid;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [3:0]   out_tag;
  logic [127:0] dp_plaintext, dp_key, dp_ciphertext;
  logic         busy;

  always #5 clk = ~clk;

  aes_encr_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .key_load(key_load), .key_in(key_in), .key_ack(key_ack), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .dp_plaintext(dp_plaintext), .dp_key(dp_key), .dp_ciphertext(dp_ciphertext),
    .busy(busy)
  );

  // Stand-in cipher: one known-answer pair, otherwise a cheap key-dependent mix.
  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
    if (pt == KAT_PT && key == KAT_KEY) return KAT_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'hc3c3_5a5a_0f0f_9696_c3c3_5a5a_0f0f_9696;
  endfunction

  logic [127:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= enc(dp_plaintext, dp_key);
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_ciphertext = dp_pipe[LAT-1];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted block is an entry that becomes visible LAT+1 edges after its accept edge.
  typedef struct {
    logic [127:0] dat;
    logic [3:0]   tag;
    int           rdy;
  } ent_t;
  ent_t         q[$];
  bit           m_have_key = 0;
  bit           m_drain = 0;
  logic [127:0] m_key = '0;
  logic [127:0] m_pt = '0;

  always @(negedge clk) begin : cmp
    int infl;
    bit ov, ack, rdy;
    if (!rst_n) begin
      q.delete();
      m_have_key = 0; m_drain = 0; m_key = '0; m_pt = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dp_key", dp_key, 0);
      chk("rst_dp_plaintext", dp_plaintext, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
    end else begin
      infl = 0;
      foreach (q[i]) if (q[i].rdy > cyc) infl++;
      ov  = (q.size() > 0) && (q[0].rdy <= cyc);
      ack = key_load && (!m_have_key || (m_drain && infl == 0));
      rdy = m_have_key && !m_drain && !key_load && (q.size() < DEPTH);
      chk("in_ready", in_ready, rdy);
      chk("key_ack", key_ack, ack);
      chk("key_valid", key_valid, m_have_key);
      chk("out_valid", out_valid, ov);
      chk("busy", busy, q.size() != 0);
      chk("dp_key", dp_key, m_key);
      chk("dp_plaintext", dp_plaintext, m_pt);
      if (ov) begin
        chk("out_data", out_data, q[0].dat);
        chk("out_tag", out_tag, q[0].tag);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        q.push_back('{dat: enc(in_data, m_key), tag: in_tag, rdy: cyc + LAT + 2});
        m_pt = in_data;
      end
      if (ack) begin
        m_key = key_in; m_have_key = 1; m_drain = 0;
      end else if (m_have_key && key_load) begin
        m_drain = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1; key_in = k;
    step();
    key_load = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, acc, pops;
    int got_tags[$];
    logic [3:0] tg;

    repeat (3) step();
    chk("reset_key_valid", key_valid, 0);
    rst_n = 1'b1;
    step();

    // Blocks offered before any key are never accepted.
    in_valid = 1'b1; in_data = 128'h1234; out_ready = 1'b1;
    acc = 0; pops = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) acc++;
      if (out_valid) pops++;
      step();
    end
    chk("nokey_ready_cycles", acc, 0);
    chk("nokey_out_cycles", pops, 0);
    in_valid = 1'b0;

    // Known-answer block: ack is combinational in NOKEY, output after LAT+1 edges.
    key_load = 1'b1; key_in = KAT_KEY;
    #1;
    chk("kat_key_ack", key_ack, 1);
    step();
    key_load = 1'b0;
    #1;
    chk("kat_key_ack_drop", key_ack, 0);
    chk("kat_key_valid", key_valid, 1);
    in_valid = 1'b1; in_data = KAT_PT; in_tag = 4'd3;
    #1;
    chk("kat_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("kat_latency", n, 11);
    chk("kat_out_data", out_data, KAT_CT);
    chk("kat_out_tag", out_tag, 3);
    step();

    // Backpressure: 10 cycles of offers with the consumer stalled.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 128'(32'h100 + acc); in_tag = 4'(acc);
      #1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, DEPTH);
    repeat (12) step();
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1; pops = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) pops++;
      step();
    end
    chk("bp_pops", pops, DEPTH);
    chk("bp_in_ready_resume", in_ready, 1);
    chk("bp_busy_idle", busy, 0);

    // Key change with three blocks in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 128'(32'h200 + i); in_tag = 4'(8 + i);
      step();
    end
    key_load = 1'b1; key_in = KEY2; in_data = 128'h300; in_tag = 4'd12;
    #1;
    chk("kc_ready_drop", in_ready, 0);
    n = 0;
    while (!key_ack && n < 40) begin step(); n++; end
    chk("kc_ack_wait", n, 11);
    step();
    key_load = 1'b0;
    #1;
    chk("kc_dp_key", dp_key, KEY2);
    chk("kc_new_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (15) step();

    // Asynchronous reset with blocks in flight.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 128'(32'h400 + i); in_tag = 4'(i);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_key_valid", key_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dp_key", dp_key, 0);
    repeat (2) step();
    rst_n = 1'b1;
    in_valid = 1'b1; acc = 0; pops = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) acc++;
      if (out_valid) pops++;
      step();
    end
    in_valid = 1'b0;
    chk("post_rst_ready", acc, 0);
    chk("post_rst_out", pops, 0);

    // Streaming 16 tags with push and pop overlapping once the FIFO has filled.
    load_key(KAT_KEY);
    acc = 0;
    for (int k = 0; k < 400 && got_tags.size() < 16; k++) begin
      in_valid  = (acc < 16);
      in_tag    = 4'(acc);
      in_data   = {4{32'(acc) ^ 32'ha5a5_0000}};
      out_ready = (k >= 14);
      #1;
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) got_tags.push_back(int'(out_tag));
      step();
    end
    in_valid = 1'b0;
    chk("stream_count", got_tags.size(), 16);
    for (int i = 0; i < got_tags.size(); i++) begin
      tg = 4'(i);
      chk("stream_tag_order", got_tags[i], tg);
    end
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
